// File: rtl/gfx_mem_arbiter_pkg.sv
// Shared definitions for the framebuffer memory arbiter: engine indices, op codes, bus widths.
package gfx_mem_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int GFX_ADDR_W      = 16;
  localparam int GFX_DATA_W      = 32;
  localparam int GFX_NUM_ENGINES = 4;

  typedef enum logic [1:0] {
    REQ_DISPLAY  = 2'd0,
    REQ_FILLRECT = 2'd1,
    REQ_LINE     = 2'd2,
    REQ_BLIT     = 2'd3
  } gfx_req_e;

endpackage

// File: rtl/gfx_mem_arbiter_if.sv
// Engine-side request bus, read-return broadcast and memory command port of the arbiter.
interface gfx_mem_arbiter_if
  import gfx_mem_pkg::*;
#(
  parameter int NUM_REQ = GFX_NUM_ENGINES,
  parameter int ADDR_W  = GFX_ADDR_W,
  parameter int DATA_W  = GFX_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_in_rts;
  logic [NUM_REQ-1:0]        req_out_rtr;
  logic [NUM_REQ-1:0]        req_in_op;
  logic [NUM_REQ*ADDR_W-1:0] req_in_addr;
  logic [NUM_REQ*DATA_W-1:0] req_in_data;
  logic [NUM_REQ*BE_W-1:0]   req_in_wben;
  logic [DATA_W-1:0]         bcast_out_data;
  logic [NUM_REQ-1:0]        bcast_out_xfc;
  logic                      mem_out_en;
  logic [BE_W-1:0]           mem_out_we;
  logic [ADDR_W-1:0]         mem_out_addr;
  logic [DATA_W-1:0]         mem_out_data;
  logic [DATA_W-1:0]         mem_in_data;

  modport slave (
    input  req_in_rts, req_in_op, req_in_addr, req_in_data, req_in_wben, mem_in_data,
    output req_out_rtr, bcast_out_data, bcast_out_xfc,
    output mem_out_en, mem_out_we, mem_out_addr, mem_out_data
  );

  modport master (
    output req_in_rts, req_in_op, req_in_addr, req_in_data, req_in_wben, mem_in_data,
    input  req_out_rtr, bcast_out_data, bcast_out_xfc,
    input  mem_out_en, mem_out_we, mem_out_addr, mem_out_data
  );

endinterface

// File: rtl/gfx_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted rts strictly after ptr, wrapping modulo NUM_REQ.
module gfx_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] rts,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand_s;
  logic             take_s;

  // Scan ptr+1 .. ptr+NUM_REQ; ptr itself is visited last so a lone requester still wins.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    take_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s      = IDX_W'((int'(ptr) + k) % NUM_REQ);
      take_s      = rts[cand_s] & ~any;
      gnt[cand_s] = gnt[cand_s] | take_s;
      idx         = take_s ? cand_s : idx;
      any         = any | take_s;
    end
  end

endmodule

// File: rtl/gfx_mem_arbiter.sv
// Round-robin arbiter sharing one pipelined framebuffer SRAM port between graphics engines,
// with bounded bursts, registered memory commands and a tagged read-return broadcast.
module gfx_mem_arbiter
  import gfx_mem_pkg::*;
#(
  parameter int NUM_REQ   = GFX_NUM_ENGINES,
  parameter int ADDR_W    = GFX_ADDR_W,
  parameter int DATA_W    = GFX_DATA_W,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_,
  gfx_mem_arbiter_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [IDX_W-1:0]   owner_r;
  logic               owner_vld_r;
  logic [CNT_W-1:0]   burst_cnt_r;

  logic [NUM_REQ-1:0] pick_gnt_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;

  logic               keep_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic               gnt_any_s;
  logic [CNT_W-1:0]   cnt_nxt_s;

  logic               sel_op_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [BE_W-1:0]    sel_wben_s;

  logic               mem_en_r;
  logic [BE_W-1:0]    mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_data_r;

  logic [RD_LAT:0]    tag_vld_r;
  logic [IDX_W-1:0]   tag_idx_r [0:RD_LAT];
  logic [NUM_REQ-1:0] xfc_r;
  logic [DATA_W-1:0]  bdata_r;

  gfx_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .rts (bus.req_in_rts),
    .ptr (owner_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Grant selection: owner keeps the slot while its burst budget lasts, otherwise rotate.
  // owner_vld_r is clear only after reset, so the first grant always comes from the rotation.
  always_comb begin
    keep_s    = owner_vld_r && bus.req_in_rts[owner_r] &&
                (burst_cnt_r < CNT_W'(MAX_BURST - 1));
    gnt_s     = '0;
    gnt_idx_s = owner_r;
    gnt_any_s = 1'b0;
    cnt_nxt_s = burst_cnt_r;
    if (keep_s) begin
      gnt_s[owner_r] = 1'b1;
      gnt_any_s      = 1'b1;
      cnt_nxt_s      = burst_cnt_r + CNT_W'(1);
    end else if (pick_any_s) begin
      gnt_s     = pick_gnt_s;
      gnt_idx_s = pick_idx_s;
      gnt_any_s = 1'b1;
      // A lone owner wins the rotation again: the count stays saturated.
      cnt_nxt_s = (owner_vld_r && (pick_idx_s == owner_r)) ? burst_cnt_r : '0;
    end else begin
      gnt_s     = '0;
      gnt_any_s = 1'b0;
    end
  end

  // Fields of the granted requester.
  always_comb begin
    sel_op_s   = bus.req_in_op[gnt_idx_s];
    sel_addr_s = bus.req_in_addr[gnt_idx_s*ADDR_W +: ADDR_W];
    sel_data_s = bus.req_in_data[gnt_idx_s*DATA_W +: DATA_W];
    sel_wben_s = bus.req_in_wben[gnt_idx_s*BE_W +: BE_W];
  end

  // Owner pointer and burst counter advance only on a grant.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      owner_r     <= IDX_W'(NUM_REQ - 1);
      owner_vld_r <= 1'b0;
      burst_cnt_r <= '0;
    end else if (gnt_any_s) begin
      owner_r     <= gnt_idx_s;
      owner_vld_r <= 1'b1;
      burst_cnt_r <= cnt_nxt_s;
    end
  end

  // Memory command register; idle cycles drive an all-zero command.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_en_r   <= 1'b0;
      mem_we_r   <= '0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
    end else begin
      mem_en_r   <= gnt_any_s;
      mem_we_r   <= (gnt_any_s && (sel_op_s == OP_WRITE)) ? sel_wben_s : '0;
      mem_addr_r <= gnt_any_s ? sel_addr_s : '0;
      mem_data_r <= gnt_any_s ? sel_data_s : '0;
    end
  end

  // Read tag pipeline: stage k holds the read issued to memory k cycles ago.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      tag_vld_r <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_idx_r[k] <= '0;
    end else begin
      tag_vld_r[0] <= gnt_any_s && (sel_op_s == OP_READ);
      tag_idx_r[0] <= gnt_idx_s;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_idx_r[k] <= tag_idx_r[k-1];
      end
    end
  end

  // Register returning data and strobe; data holds between returns.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      xfc_r   <= '0;
      bdata_r <= '0;
    end else begin
      xfc_r   <= tag_vld_r[RD_LAT] ? (NUM_REQ'(1) << tag_idx_r[RD_LAT]) : '0;
      bdata_r <= tag_vld_r[RD_LAT] ? bus.mem_in_data : bdata_r;
    end
  end

  assign bus.req_out_rtr    = gnt_s;
  assign bus.mem_out_en     = mem_en_r;
  assign bus.mem_out_we     = mem_we_r;
  assign bus.mem_out_addr   = mem_addr_r;
  assign bus.mem_out_data   = mem_data_r;
  assign bus.bcast_out_xfc  = xfc_r;
  assign bus.bcast_out_data = bdata_r;

endmodule

// File: doc/gfx_mem_arbiter.md
Name: gfx_mem_arbiter

Overview:
Shares the single framebuffer memory port between the graphics engines: fill-rect, line, blit, and display-refresh readers. Each engine presents read/write transactions with an rts/rtr handshake. The arbiter grants one transaction per cycle with round-robin priority and bounded bursts, and issues the transaction to pipelined SRAM. Read data returns on a shared broadcast bus, marked by a one-hot per-requester xfc strobe.

Parameters:
NUM_REQ, 4, number of requesting engines (2..8)
ADDR_W, 16, word address width
DATA_W, 32, data width; byte-enable width is DATA_W/8
RD_LAT, 2, memory read latency in cycles from command-sample edge to mem_in_data valid (1..4)
MAX_BURST, 4, max consecutive grants to one requester while others wait (1..16)

Ports:
clk  in  1  clock
rst_  in  1  asynchronous active-low reset
req_in_rts  in  NUM_REQ  per-requester transaction request
req_out_rtr  out  NUM_REQ  per-requester grant; one-hot or zero
req_in_op  in  NUM_REQ  per-requester op: 1 = write, 0 = read
req_in_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_in_data  in  NUM_REQ*DATA_W  packed write data
req_in_wben  in  NUM_REQ*DATA_W/8  packed byte enables, 1 = write byte
bcast_out_data  out  DATA_W  read-return data, shared by all requesters
bcast_out_xfc  out  NUM_REQ  one-hot read-return strobe
mem_out_en  out  1  memory command valid
mem_out_we  out  DATA_W/8  byte write enables; all zero = read
mem_out_addr  out  ADDR_W  memory address
mem_out_data  out  DATA_W  memory write data
mem_in_data  in  DATA_W  memory read data

Behaviour:
- Reset: all outputs go to 0, owner pointer goes to NUM_REQ-1 (requester 0 wins first), burst_cnt goes to 0, and the return pipeline is cleared. Reset mid-operation drops in-flight reads; no xfc is ever issued for them.
- Transfer occurs in a cycle where req_in_rts[i] & req_out_rtr[i] is true. Requesters hold op/addr/data/wben stable while rts is high and not yet granted. The arbiter must not depend on this for correctness.
- req_out_rtr is combinational from rts, the owner pointer and burst_cnt. At most one bit is set. It is 0 when no rts is high.
- Grant selection:
  - If the owner's rts is high and burst_cnt < MAX_BURST-1, the owner keeps the grant and burst_cnt increments.
  - Otherwise, search from owner+1 upward, wrapping modulo NUM_REQ, and grant the first rts. Owner becomes that requester and burst_cnt becomes 0.
  - If the owner is the only requester, it keeps the grant indefinitely. burst_cnt saturates and no rotation occurs.
- Command path, registered: a transfer in cycle N gives mem_out_en=1 in cycle N+1, with that requester's addr/data.
  - Write: mem_out_we = wben.
  - Read: mem_out_we = 0.
  - A write with wben=0 is issued as a command with no byte enables and produces no xfc.
  - A cycle with no grant gives mem_out_en=0, and mem_out_we, addr and data go to 0.
- Read return: a tag pipeline (valid + requester index) of depth RD_LAT+1 tracks each read. Memory data is valid in cycle N+1+RD_LAT and is registered. bcast_out_data and bcast_out_xfc[i] are therefore valid in cycle N+2+RD_LAT, for one cycle.
  - bcast_out_data holds its last value when xfc is 0.
- Back-to-back reads from any mix of requesters are accepted every cycle. Returns arrive in issue order with no stalls.
- A grant and a read return in the same cycle are independent. There is no memory backpressure.
- Throughput is one transaction per cycle.

Decomposition:
- Shared package gfx_mem_pkg holds: OP_READ=1'b0, OP_WRITE=1'b1, GFX_ADDR_W=16, GFX_DATA_W=32, and GFX_NUM_ENGINES with fixed requester indices (REQ_DISPLAY=0, REQ_FILLRECT=1, REQ_LINE=2, REQ_BLIT=3).
- One sub-module: gfx_rr_pick. It is combinational; inputs are rts vector and pointer, outputs are one-hot grant and index.
- Burst counter, command registers and return pipeline stay in the top module.

Test Plan:
- Single read: req1 reads addr 0x0010 at cycle 5, memory model returns 0xDEADBEEF. Expected: mem_out_en=1 with mem_out_we=0 at cycle 6; bcast_out_data=0xDEADBEEF with bcast_out_xfc=4'b0010 at cycle 9 (RD_LAT=2).
- Fairness: all four rts held high with MAX_BURST=1. Expected grant order 0,1,2,3,0,1,… with one grant per cycle and no gaps.
- Burst: req2 and req3 continuously high with MAX_BURST=4. Expected grant sequence 2,2,2,2,3,3,3,3,2,…
- Mixed pipeline: req0 read 0x0100, req1 write 0x0200 = 0x12345678 with wben=4'b0011, req3 read 0x0300, on consecutive cycles. Expected: memory sees write with mem_out_we=4'b0011; xfc sequence 0001, none, 1000 on consecutive cycles with the correct data.
- Reset mid-flight: issue two reads, assert rst_ low one cycle after the second grant. Expected: all outputs 0 immediately, no xfc after release, and requester 0 wins first after reset.
- Idle: no rts. Expected: rtr=0, mem_out_en=0 and bcast_out_xfc=0 for 20 cycles; burst_cnt is not advanced.
